reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter: N_SRC, 2, number of reset request sources (1..8); bit 0 is power-fail.
REQ-002 Parameter: HOLD_CYCLES, 16, cycles of reset hold after all sources release (2..256).
REQ-003 Parameter: DEB_CYCLES, 4, consecutive high cycles to qualify a non-power source (1..255).
REQ-004 Parameter: VECTOR, 16'hFFF0, reset vector driven on the bus.
REQ-005 Parameter: WD_CYCLES, 4096, watchdog timeout in cycles; used only with the watchdog macro.
REQ-006 Port: clk1  input  1  system clock; one clock, all logic on rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high block reset.
REQ-008 Port: src_req  input  N_SRC  asynchronous reset requests, active-high.
REQ-009 Port: go_fetch  input  1  sequencer acknowledgement that the vector was fetched.
REQ-010 Port: wd_kick  input  1  watchdog restart pulse, active-high.
REQ-011 Port: cause_clr  input  1  clears rst_cause, active-high.
REQ-012 Port: nreset_out  output  1  system reset, active-low.
REQ-013 Port: nrsthold  output  1  reset hold, active-low; also the vector-enable strobe.
REQ-014 Port: ir_rst  output  1  instruction-register reset, active-high.
REQ-015 Port: ibus_out  output  16  vector data.
REQ-016 Port: ibus_oe  output  1  bus drive enable for ibus_out.
REQ-017 Port: rst_cause  output  N_SRC+1  sticky cause bits; bit N_SRC is watchdog.

Function
REQ-018 Each src_req bit shall pass through a 2-FF synchroniser.
REQ-019 Bits 1..N_SRC-1 shall qualify after DEB_CYCLES consecutive synchronised-high cycles and release on the first low cycle.
REQ-020 Bit 0 shall qualify immediately after synchronisation, with no debounce.
REQ-021 The FSM shall have the states ASSERT, HOLD, VECTOR and RUN.
REQ-022 ASSERT: nreset_out=0, nrsthold=0, ir_rst=1; go to HOLD with the counter at 0 on the first cycle no source is qualified.
REQ-023 HOLD: nreset_out=1, nrsthold=0, ir_rst=1; the counter increments each cycle; go to VECTOR when the count reaches HOLD_CYCLES-1.
REQ-024 VECTOR: nrsthold=0, ibus_oe=1, ibus_out=VECTOR, ir_rst=~go_fetch; go to RUN on the cycle after go_fetch=1.
REQ-025 RUN: nreset_out=1, nrsthold=1, ir_rst=0, ibus_oe=0.
REQ-026 A qualified source in any state shall force ASSERT on the next cycle, aborting HOLD or VECTOR; the counter clears.
REQ-027 When ibus_oe=0, ibus_out shall be 16'h0000.
REQ-028 go_fetch outside VECTOR shall be ignored.
REQ-029 rst_cause bit k shall set when source k qualifies.
REQ-030 cause_clr shall clear rst_cause only in RUN; set wins over clear in the same cycle.
REQ-031 The hold counter width shall be $clog2(HOLD_CYCLES) and shall never wrap in HOLD.

Reset
REQ-032 reset=1 shall force ASSERT, clear the counters and synchronisers, and set rst_cause to 1 (bit 0 only, power-on).
REQ-033 Outputs during reset shall be nreset_out=0, nrsthold=0, ir_rst=1, ibus_oe=0, ibus_out=0.
REQ-034 Release of reset shall follow REQ-022 to REQ-024.

Configuration
REQ-035 With RESET_WATCHDOG_EN defined, a WD counter shall run in RUN only; it clears on wd_kick or on leaving RUN.
REQ-036 With RESET_WATCHDOG_EN defined, reaching WD_CYCLES-1 without a kick shall set rst_cause[N_SRC] and force ASSERT for exactly one cycle, then normal sequencing.
REQ-037 With RESET_WATCHDOG_EN undefined, there shall be no watchdog logic, wd_kick shall be ignored, and rst_cause[N_SRC] shall be tied to 0.

Structure
REQ-038 Package reset_pkg shall hold the state enum (ASSERT, HOLD, VECTOR, RUN) and the default constants (VECTOR, HOLD_CYCLES, DEB_CYCLES).
REQ-039 Sub-module reset_debounce shall handle one source (synchroniser plus debounce counter); it is instantiated N_SRC times with a bypass for bit 0.

Verification
REQ-040 Reset 1 cycle, defaults, no sources -> nreset_out=1 at cycle 2; nrsthold=0 for 16 HOLD cycles plus VECTOR; ibus_out=16'hFFF0; go_fetch -> nrsthold=1 the next cycle; rst_cause=3'b001.
REQ-041 src_req[1] high for 3 cycles in RUN -> no reset; high for 4 cycles -> ASSERT; rst_cause[1]=1.
REQ-042 src_req[0] pulse at HOLD count 10 -> ASSERT 3 cycles later; HOLD restarts from 0 and runs the full 16 cycles.
REQ-043 cause_clr together with a src_req[1] qualification -> rst_cause[1] stays 1; cause_clr alone in RUN -> rst_cause=0.
REQ-044 RESET_WATCHDOG_EN, WD_CYCLES=100, no kick -> ASSERT after 100 RUN cycles; rst_cause[2]=1; kick every 50 cycles -> no reset.
REQ-045 go_fetch in HOLD -> ignored; VECTOR is still entered with ir_rst=1.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared state type and default constants for the reset sequencer.
package reset_pkg;

    // state      | meaning
    // ST_ASSERT  | system and hold resets asserted while any source is qualified
    // ST_HOLD    | system reset released, hold counter running
    // ST_VECTOR  | reset vector driven on the bus until the fetch is acknowledged
    // ST_RUN     | normal operation
    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RUN    = 2'd3
    } rst_state_e;

    localparam int          DEF_HOLD_CYCLES = 16;
    localparam int          DEF_DEB_CYCLES  = 4;
    localparam logic [15:0] DEF_VECTOR      = 16'hFFF0;
    localparam int          DEF_WD_CYCLES   = 4096;

endpackage

// File: rtl/reset_debounce.sv
// One reset request source: 2-FF synchroniser, then a consecutive-high qualifier.
// BYPASS=1 qualifies directly from the synchroniser output (power-fail source).
module reset_debounce
    import reset_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter bit BYPASS     = 1'b0
) (
    input  logic clk1,
    input  logic reset,
    input  logic req_in,
    output logic qual
);

    localparam int            CW       = 8;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] deb_cnt_q;
    logic [CW-1:0] deb_cnt_d;

    // Counts previous consecutive high cycles; saturates so a held request stays qualified.
    always_comb begin
        deb_cnt_d = '0;
        if (sync2_q) begin
            deb_cnt_d = (deb_cnt_q == DEB_LAST) ? deb_cnt_q : deb_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= req_in;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign qual = BYPASS ? sync2_q : (sync2_q && (deb_cnt_q == DEB_LAST));

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies reset requests and steps ASSERT -> HOLD -> VECTOR -> RUN.
// Define RESET_WATCHDOG_EN to add a RUN-state watchdog that forces a one-cycle ASSERT.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int          N_SRC       = 2,
    parameter int          HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int          DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter logic [15:0] VECTOR      = DEF_VECTOR,
    parameter int          WD_CYCLES   = DEF_WD_CYCLES
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_req,
    input  logic             go_fetch,
    input  logic             wd_kick,
    input  logic             cause_clr,
    output logic             nreset_out,
    output logic             nrsthold,
    output logic             ir_rst,
    output logic [15:0]      ibus_out,
    output logic             ibus_oe,
    output logic [N_SRC:0]   rst_cause
);

    localparam int            HW        = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [N_SRC-1:0] src_qual;
    logic             wd_fire;
    logic             force_rst;
    logic [N_SRC:0]   cause_set;

    rst_state_e       state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [N_SRC:0]   cause_q, cause_d;
    logic             nreset_out_q, nreset_out_d;
    logic             nrsthold_q, nrsthold_d;
    logic             ir_rst_q, ir_rst_d;
    logic             ibus_oe_q, ibus_oe_d;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        reset_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .BYPASS    (i == 0)
        ) u_deb (
            .clk1  (clk1),
            .reset (reset),
            .req_in(src_req[i]),
            .qual  (src_qual[i])
        );
    end

`ifdef RESET_WATCHDOG_EN
    localparam int            WW      = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);

    logic [WW-1:0] wd_cnt_q, wd_cnt_d;

    // Counter is held at zero outside RUN, so every RUN entry starts a fresh timeout.
    always_comb begin
        wd_cnt_d = '0;
        wd_fire  = 1'b0;
        if (state_q == ST_RUN && !wd_kick) begin
            if (wd_cnt_q == WD_LAST) wd_fire = 1'b1;
            else                     wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) wd_cnt_q <= '0;
        else       wd_cnt_q <= wd_cnt_d;
    end
`else
    logic [31:0] unused_wd;
    assign unused_wd = {WD_CYCLES[30:0], wd_kick};
    assign wd_fire   = 1'b0;
`endif

    always_comb begin
        force_rst  = (|src_qual) | wd_fire;
        cause_set  = {wd_fire, src_qual};
        state_d    = state_q;
        hold_cnt_d = '0;
        if (force_rst) begin
            state_d = ST_ASSERT;
        end else begin
            case (state_q)
                ST_ASSERT: state_d = ST_HOLD;
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) state_d = ST_VECTOR;
                    else                         hold_cnt_d = hold_cnt_q + 1'b1;
                end
                ST_VECTOR: if (go_fetch) state_d = ST_RUN;
                ST_RUN:    state_d = ST_RUN;
                default:   state_d = ST_ASSERT;
            endcase
        end

        // A new cause in the same cycle as the clear is kept.
        cause_d = ((state_q == ST_RUN && cause_clr) ? '0 : cause_q) | cause_set;

        nreset_out_d = (state_d != ST_ASSERT);
        nrsthold_d   = (state_d == ST_RUN);
        ir_rst_d     = (state_d != ST_RUN);
        ibus_oe_d    = (state_d == ST_VECTOR);
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q      <= ST_ASSERT;
            hold_cnt_q   <= '0;
            cause_q      <= (N_SRC + 1)'(1);
            nreset_out_q <= 1'b0;
            nrsthold_q   <= 1'b0;
            ir_rst_q     <= 1'b1;
            ibus_oe_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cause_q      <= cause_d;
            nreset_out_q <= nreset_out_d;
            nrsthold_q   <= nrsthold_d;
            ir_rst_q     <= ir_rst_d;
            ibus_oe_q    <= ibus_oe_d;
        end
    end

    // The instruction register leaves reset as soon as the fetch is acknowledged.
    assign ir_rst     = ir_rst_q & ~(ibus_oe_q & go_fetch);
    assign nreset_out = nreset_out_q;
    assign nrsthold   = nrsthold_q;
    assign ibus_oe    = ibus_oe_q;
    assign ibus_out   = ibus_oe_q ? VECTOR : 16'h0000;
    assign rst_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed vector table plus randomized
// stimulus against a timeline model (cycles since last forced reset, fetch flag).
module tb_reset_sequencer;

    localparam int          N_SRC = 2;
    localparam int          HOLD  = 16;
    localparam int          DEB   = 4;
    localparam int          TB_WD = 100;
    localparam logic [15:0] VEC   = 16'hFFF0;

    logic             clk1 = 1'b0;
    logic             reset;
    logic [N_SRC-1:0] src_req;
    logic             go_fetch, wd_kick, cause_clr;
    logic             nreset_out, nrsthold, ir_rst, ibus_oe;
    logic [15:0]      ibus_out;
    logic [N_SRC:0]   rst_cause;

    reset_sequencer #(
        .N_SRC      (N_SRC),
        .HOLD_CYCLES(HOLD),
        .DEB_CYCLES (DEB),
        .VECTOR     (VEC),
        .WD_CYCLES  (TB_WD)
    ) dut (
        .clk1      (clk1),
        .reset     (reset),
        .src_req   (src_req),
        .go_fetch  (go_fetch),
        .wd_kick   (wd_kick),
        .cause_clr (cause_clr),
        .nreset_out(nreset_out),
        .nrsthold  (nrsthold),
        .ir_rst    (ir_rst),
        .ibus_out  (ibus_out),
        .ibus_oe   (ibus_oe),
        .rst_cause (rst_cause)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase follows from edges since the last forced reset.
    bit               m_valid = 1'b0;
    logic [N_SRC-1:0] m_s1, m_s2;
    int               m_run[N_SRC];
    int               m_quiet;
    bit               m_fetched;
    logic [N_SRC:0]   m_cause;
    int               m_wd_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // 0 = assert, 1 = hold, 2 = vector, 3 = run
    function automatic int m_phase();
        if (m_quiet == 0)    return 0;
        if (m_quiet <= HOLD) return 1;
        if (!m_fetched)      return 2;
        return 3;
    endfunction

    function automatic logic [N_SRC-1:0] m_qual();
        logic [N_SRC-1:0] q;
        for (int k = 0; k < N_SRC; k++)
            q[k] = (k == 0) ? m_s2[0] : (m_s2[k] && (m_run[k] >= DEB));
        return q;
    endfunction

    task automatic model_check();
        int ph;
        if (m_valid) begin
            ph = m_phase();
            chk("nreset_out", nreset_out, ph != 0);
            chk("nrsthold",   nrsthold,   ph == 3);
            chk("ir_rst",     ir_rst,     (ph == 2) ? !go_fetch : (ph != 3));
            chk("ibus_oe",    ibus_oe,    ph == 2);
            chk("ibus_out",   ibus_out,   (ph == 2) ? VEC : 16'h0000);
            chk("rst_cause",  rst_cause,  m_cause);
        end
    endtask

    task automatic model_step();
        int               ph;
        logic [N_SRC-1:0] q;
        logic             wd_to;
        ph    = m_phase();
        q     = m_qual();
        wd_to = 1'b0;
`ifdef RESET_WATCHDOG_EN
        if (ph == 3 && !wd_kick && (cyc - m_wd_start) == TB_WD - 1) wd_to = 1'b1;
`endif
        if (reset) begin
            m_valid   = 1'b1;
            m_s1      = '0;
            m_s2      = '0;
            for (int k = 0; k < N_SRC; k++) m_run[k] = 0;
            m_quiet   = 0;
            m_fetched = 1'b0;
            m_cause   = 1;
        end else if (m_valid) begin
            m_cause = ((ph == 3 && cause_clr) ? '0 : m_cause) | {wd_to, q};
            if (q != 0 || wd_to) begin
                m_quiet   = 0;
                m_fetched = 1'b0;
            end else begin
                if (ph == 2 && go_fetch) m_fetched = 1'b1;
                if (m_quiet < 100000) m_quiet++;
            end
            m_s2 = m_s1;
            m_s1 = src_req;
            for (int k = 0; k < N_SRC; k++) m_run[k] = m_s2[k] ? m_run[k] + 1 : 0;
        end
        if (ph != 3 || wd_kick) m_wd_start = cyc + 1;
        cyc++;
    endtask

    task automatic apply(input logic [N_SRC-1:0] s, input logic g, input logic k,
                         input logic c, input logic r);
        @(negedge clk1);
        src_req = s; go_fetch = g; wd_kick = k; cause_clr = c; reset = r;
        #1;
        model_check();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply('0, 1'b0, 1'b0, 1'b0, 1'b0);
            advance();
        end
    endtask

    typedef struct {
        logic [N_SRC-1:0] src;
        logic             gf, clr, rst;
        int               reps;
        logic             nres, nhold, ir, oe;
        logic [15:0]      bus;
        logic [N_SRC:0]   cause;
    } vec_t;

    vec_t tbl[22];

    logic [N_SRC-1:0] r_src;
    int               burst1;

    initial begin
        src_req = '0; go_fetch = 1'b0; wd_kick = 1'b0; cause_clr = 1'b0; reset = 1'b1;

        //            src    gf    clr   rst  reps nres  nhold ir    oe    bus       cause
        tbl[0]  = '{2'b00, 1'b0, 1'b0, 1'b1, 2,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b001};
        tbl[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b001};
        tbl[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b001};
        tbl[3]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b1, 1'b1, 16'hFFF0, 3'b001};
        tbl[4]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b1, 16'hFFF0, 3'b001};
        tbl[5]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b001};
        tbl[6]  = '{2'b10, 1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b001};
        tbl[7]  = '{2'b00, 1'b0, 1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b001};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b001};
        tbl[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000};
        tbl[10] = '{2'b10, 1'b0, 1'b0, 1'b0, 5,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000};
        tbl[11] = '{2'b10, 1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b010};
        tbl[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b010};
        tbl[14] = '{2'b00, 1'b0, 1'b0, 1'b0, 9,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b010};
        tbl[15] = '{2'b01, 1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b010};
        tbl[16] = '{2'b00, 1'b0, 1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b010};
        tbl[17] = '{2'b00, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b011};
        tbl[18] = '{2'b00, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b011};
        tbl[19] = '{2'b00, 1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 1'b1, 16'hFFF0, 3'b011};
        tbl[20] = '{2'b00, 1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b1, 16'hFFF0, 3'b011};
        tbl[21] = '{2'b00, 1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b011};

        for (int i = 0; i < 22; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                apply(tbl[i].src, tbl[i].gf, 1'b0, tbl[i].clr, tbl[i].rst);
                if (r == tbl[i].reps - 1) begin
                    chk($sformatf("tbl%0d nreset_out", i), nreset_out, tbl[i].nres);
                    chk($sformatf("tbl%0d nrsthold", i),   nrsthold,   tbl[i].nhold);
                    chk($sformatf("tbl%0d ir_rst", i),     ir_rst,     tbl[i].ir);
                    chk($sformatf("tbl%0d ibus_oe", i),    ibus_oe,    tbl[i].oe);
                    chk($sformatf("tbl%0d ibus_out", i),   ibus_out,   tbl[i].bus);
                    chk($sformatf("tbl%0d rst_cause", i),  rst_cause,  tbl[i].cause);
                end
                advance();
            end
        end

`ifdef RESET_WATCHDOG_EN
        // RUN cycle 1 was the last table row; cycles 2..99 still run.
        idle(98);
        apply('0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd run cycle 100", nrsthold, 1'b1);
        advance();
        apply('0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd assert", nreset_out, 1'b0);
        chk("wd cause", rst_cause, 3'b111);
        advance();
        apply('0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd assert one cycle", nreset_out, 1'b1);
        advance();
        for (int i = 0; i < 40 && m_phase() != 3; i++) begin
            apply('0, 1'b1, 1'b0, 1'b0, 1'b0);
            advance();
        end
        chk("wd back to run", m_phase(), 3);
        for (int i = 0; i < 4; i++) begin
            idle(49);
            apply('0, 1'b0, 1'b1, 1'b0, 1'b0);
            advance();
        end
        apply('0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wd kicked stays run", nrsthold, 1'b1);
        advance();
`endif

        burst1 = 0;
        for (int i = 0; i < 3000; i++) begin
            r_src = '0;
            if (burst1 > 0) begin
                r_src[1] = 1'b1;
                burst1--;
            end else if ($urandom_range(0, 39) == 0) begin
                burst1 = $urandom_range(1, 7);
            end
            r_src[0] = ($urandom_range(0, 149) == 0);
            apply(r_src, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 499) == 0);
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
